bus_cmd_master: RTL and testbench

//  Initiator side of the ic0 single-beat register bus. Takes one command at a time (read or write)
//  on a valid/ready command port, issues it on ic0 to one or more slaves (GPIO and peers),

---
 rtl/bus_cmd_master.sv | 198 +++++++++++++++++++
 tb/tb_bus_cmd_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cmd_master.sv
// ---------------------------------------------------------------------------
// bus_cmd_master
//   Initiator side of the ic0 single-beat register bus. Accepts one command
//   at a time on a valid/ready port, issues it as a single-cycle strobe on
//   ic0, waits for the read return (or a fixed commit gap for writes) and
//   hands back exactly one response per command, flagging read timeouts.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_wr/addr/data          command fields (data ignored on reads)
//   rsp_valid/rsp_ready       response handshake, response held until taken
//   rsp_data/rsp_err          read data (0 for writes, ERR_DATA on timeout)
//   ic0_c_axi_mst_wr_valid    one-cycle write strobe
//   ic0_axi_mst_wr_addr/data  write address/data, valid with the strobe
//   ic0_c_axi_mst_rd_valid    one-cycle read strobe
//   ic0_axi_mst_rd_addr       read address, valid with the strobe
//   ic0_c_axi_slv_rd_ready    per-slave read-return strobes
//   ic0_axi_slv_rd_data       per-slave read data, slot i = [32*i+31:32*i]
//
// State          | meaning
// ---------------+-----------------------------------------------------------
// S_IDLE         | ready for a command
// S_WR_ISSUE     | write strobe on ic0 (one cycle)
// S_WR_GAP       | let the slave commit the write before responding
// S_RD_ISSUE     | read strobe on ic0 (one cycle), a return is already taken
// S_RD_WAIT      | waiting for any slave read return or the timeout
// S_RSP          | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module bus_cmd_master #(
  parameter int          NSLV     = 1,
  parameter int          TIMEOUT  = 16,
  parameter int          WR_GAP   = 2,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 ic0_c_axi_mst_wr_valid,
  output logic [31:0]          ic0_axi_mst_wr_addr,
  output logic [31:0]          ic0_axi_mst_wr_data,
  output logic                 ic0_c_axi_mst_rd_valid,
  output logic [31:0]          ic0_axi_mst_rd_addr,
  input  logic [NSLV-1:0]      ic0_c_axi_slv_rd_ready,
  input  logic [32*NSLV-1:0]   ic0_axi_slv_rd_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_GAP   = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RSP      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, data_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [CW-1:0]   to_cnt_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;

  logic [31:0]     rd_data_or;
  logic            rd_hit;
  logic            rd_phase;
  logic            accept;
  logic            timeout_hit;
  logic            rsp_load;

  // Idle slaves drive zero, so OR-ing every slot yields the answering
  // slave's data (or the OR of several on a decode fault).
  always_comb begin
    rd_data_or = '0;
    for (int i = 0; i < NSLV; i++) begin
      rd_data_or = rd_data_or | ic0_axi_slv_rd_data[32*i +: 32];
    end
  end

  assign rd_hit      = |ic0_c_axi_slv_rd_ready;
  assign rd_phase    = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT);
  assign accept      = cmd_valid && (state_q == S_IDLE);
  // Last permitted wait cycle without a return: the count reaches TIMEOUT
  // on the same edge that moves to the error response.
  assign timeout_hit = (state_q == S_RD_WAIT) && !rd_hit && (to_cnt_q == TO_LAST);
  assign rsp_load    = (state_q != S_RSP) && (state_d == S_RSP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = cmd_wr ? S_WR_ISSUE : S_RD_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        state_d = (WR_GAP == 0) ? S_RSP : S_WR_GAP;
      end
      S_WR_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_RSP;
        end
      end
      S_RD_ISSUE: begin
        state_d = rd_hit ? S_RSP : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_hit || timeout_hit) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end

      case (state_q)
        S_WR_ISSUE: gap_cnt_q <= GAP_LOAD;
        S_WR_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end
        S_RD_ISSUE: to_cnt_q <= '0;
        S_RD_WAIT: begin
          if (!rd_hit) begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
        end
        default: ;
      endcase

      // Response is captured once, on entry to S_RSP, and then held.
      if (rsp_load) begin
        if (rd_phase && rd_hit) begin
          rsp_data_q <= rd_data_or;
          rsp_err_q  <= 1'b0;
        end else if (rd_phase) begin
          rsp_data_q <= ERR_DATA;
          rsp_err_q  <= 1'b1;
        end else begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready              = (state_q == S_IDLE);
  assign rsp_valid              = (state_q == S_RSP);
  assign rsp_data               = rsp_data_q;
  assign rsp_err                = rsp_err_q;
  assign ic0_c_axi_mst_wr_valid = (state_q == S_WR_ISSUE);
  assign ic0_axi_mst_wr_addr    = addr_q;
  assign ic0_axi_mst_wr_data    = data_q;
  assign ic0_c_axi_mst_rd_valid = (state_q == S_RD_ISSUE);
  assign ic0_axi_mst_rd_addr    = addr_q;

endmodule

// File: tb/tb_bus_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_bus_cmd_master
//   Drives directed and random commands into bus_cmd_master, plays the slave
//   side, and compares every output cycle by cycle against expected values
//   computed from the command, the slave's answer delay and the rsp_ready
//   hold time.
// ---------------------------------------------------------------------------
module tb_bus_cmd_master;

  localparam int          NSLV     = 2;
  localparam int          TIMEOUT  = 8;
  localparam int          WR_GAP   = 2;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_wr;
  logic [31:0]         cmd_addr;
  logic [31:0]         cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic                wr_valid;
  logic [31:0]         wr_addr;
  logic [31:0]         wr_data;
  logic                rd_valid;
  logic [31:0]         rd_addr;
  logic [NSLV-1:0]     slv_rdy;
  logic [32*NSLV-1:0]  slv_data;

  int n_checks = 0;
  int n_fail   = 0;

  bus_cmd_master #(
    .NSLV     (NSLV),
    .TIMEOUT  (TIMEOUT),
    .WR_GAP   (WR_GAP),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_wr                 (cmd_wr),
    .cmd_addr               (cmd_addr),
    .cmd_data               (cmd_data),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_data               (rsp_data),
    .rsp_err                (rsp_err),
    .ic0_c_axi_mst_wr_valid (wr_valid),
    .ic0_axi_mst_wr_addr    (wr_addr),
    .ic0_axi_mst_wr_data    (wr_data),
    .ic0_c_axi_mst_rd_valid (rd_valid),
    .ic0_axi_mst_rd_addr    (rd_addr),
    .ic0_c_axi_slv_rd_ready (slv_rdy),
    .ic0_axi_slv_rd_data    (slv_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 32'd1);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 32'd0);
    check_eq({tag, "_rsp_err"},   rsp_err,   32'd0);
    check_eq({tag, "_rsp_data"},  rsp_data,  32'd0);
    check_eq({tag, "_wr_valid"},  wr_valid,  32'd0);
    check_eq({tag, "_rd_valid"},  rd_valid,  32'd0);
    check_eq({tag, "_wr_addr"},   wr_addr,   32'd0);
    check_eq({tag, "_wr_data"},   wr_data,   32'd0);
    check_eq({tag, "_rd_addr"},   rd_addr,   32'd0);
  endtask

  // One command from acceptance to the cycle after the response handshake.
  // Cycle c counts clock cycles after the accepting edge. The slave answers
  // d cycles after the read strobe (d = 0: same cycle); mask picks which
  // slave slots answer. h is how many extra cycles rsp_ready stays low once
  // the response is up. Called and returns at a falling edge with the
  // master expected idle.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int d, input int mask,
                         input logic [31:0] sd0, input logic [31:0] sd1, input int h);
    int          t_rsp;
    int          t_hs;
    logic [31:0] exp_data;
    logic        exp_err;
    bit          in_rsp;

    if (wr) begin
      t_rsp    = 2 + WR_GAP;
      exp_data = 32'd0;
      exp_err  = 1'b0;
    end else if (d <= TIMEOUT) begin
      t_rsp    = 2 + d;
      exp_data = (mask[0] ? sd0 : 32'd0) | (mask[1] ? sd1 : 32'd0);
      exp_err  = 1'b0;
    end else begin
      t_rsp    = 2 + TIMEOUT;
      exp_data = ERR_DATA;
      exp_err  = 1'b1;
    end
    t_hs = t_rsp + h;

    check_eq("idle_cmd_ready", cmd_ready, 32'd1);
    check_eq("idle_rsp_valid", rsp_valid, 32'd0);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;

    for (int c = 1; c <= t_hs + 1; c++) begin
      @(negedge clk);
      in_rsp = (c >= t_rsp) && (c <= t_hs);
      check_eq("wr_strobe", wr_valid, 32'(wr && (c == 1)));
      check_eq("rd_strobe", rd_valid, 32'(!wr && (c == 1)));
      check_eq("rsp_valid", rsp_valid, 32'(in_rsp));
      check_eq("cmd_ready", cmd_ready, 32'(c == t_hs + 1));
      if (c == 1) begin
        if (wr) begin
          check_eq("wr_addr", wr_addr, addr);
          check_eq("wr_data", wr_data, data);
        end else begin
          check_eq("rd_addr", rd_addr, addr);
        end
        // Scramble the command bus to prove the fields were registered.
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_data  = $urandom;
        cmd_wr    = 1'($urandom_range(0, 1));
      end
      if (in_rsp) begin
        check_eq("rsp_data", rsp_data, exp_data);
        check_eq("rsp_err",  rsp_err,  32'(exp_err));
      end

      slv_rdy  = '0;
      slv_data = '0;
      if (!wr && (c == 1 + d)) begin
        if (mask[0]) begin
          slv_rdy[0]       = 1'b1;
          slv_data[31:0]   = sd0;
        end
        if (mask[1]) begin
          slv_rdy[1]       = 1'b1;
          slv_data[63:32]  = sd1;
        end
      end else if (wr) begin
        // Stray returns during a write must be ignored.
        slv_rdy  = NSLV'($urandom_range(0, 3));
        slv_data = {$urandom, $urandom};
      end

      if (c < t_rsp) rsp_ready = 1'($urandom_range(0, 1));
      else           rsp_ready = (c == t_hs);
    end
    slv_rdy  = '0;
    slv_data = '0;
  endtask

  task automatic reset_mid_read();
    check_eq("rst_pre_cmd_ready", cmd_ready, 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = $urandom;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rst_pre_rd_strobe", rd_valid, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("rst_pre_busy", cmd_ready, 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (TIMEOUT + 3) begin
      @(negedge clk);
      check_eq("rst_post_rsp_valid", rsp_valid, 32'd0);
      check_eq("rst_post_cmd_ready", cmd_ready, 32'd1);
      check_eq("rst_post_rd_strobe", rd_valid, 32'd0);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, pick, h;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    slv_rdy   = '0;
    slv_data  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_cmd(1'b1, 32'h444, 32'hF, 0, 0, 32'h0, 32'h0, 0);
    run_cmd(1'b0, 32'h460, 32'h0, 1, 1, 32'h5, 32'h0, 1);
    run_cmd(1'b0, 32'h999, 32'h0, TIMEOUT + 1, 1, 32'h77, 32'h0, 2);
    run_cmd(1'b0, 32'h100, 32'h0, TIMEOUT, 1, 32'hA5A5_0001, 32'h0, 0);
    run_cmd(1'b0, 32'h104, 32'h0, 0, 1, 32'h1234_5678, 32'h0, 0);
    run_cmd(1'b1, 32'h200, 32'hCAFE, 0, 0, 32'h0, 32'h0, 10);
    run_cmd(1'b0, 32'h204, 32'h0, 3, 1, 32'h3C, 32'h0, 10);
    run_cmd(1'b0, 32'h300, 32'h0, 2, 2, 32'h0, 32'h12, 0);
    run_cmd(1'b0, 32'h304, 32'h0, 1, 3, 32'hF0, 32'h0F00, 0);
    run_cmd(1'b1, 32'h308, 32'h55, 0, 0, 32'h0, 32'h0, 0);
    run_cmd(1'b1, 32'h30C, 32'h66, 0, 0, 32'h0, 32'h0, 0);

    reset_mid_read();

    // Random traffic, biased toward the timeout boundaries.
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 2)      d = TIMEOUT;
      else if (pick < 3) d = TIMEOUT + 1;
      else if (pick < 4) d = 0;
      else               d = $urandom_range(0, TIMEOUT + 4);
      h = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 3);
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, d,
              $urandom_range(1, 3), $urandom, $urandom, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
